// File: rtl/dual_port_data_memory.sv
// -----------------------------------------------------------------------------
// dual_port_data_memory
//
// Word-organised, byte-writable RAM shared between the pipeline MEM stage
// (port C) and a secondary bus master (port B). One access per cycle, read-first.
// Port C has priority and keeps a 1-cycle synchronous read; port B is served in
// idle core cycles. After MAX_WAIT busy cycles port B is granted by force, and
// port C is stalled for that cycle.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   core_en               port C access request this cycle
//   core_byte_wr_en       port C byte-lane write strobes (all 0 = read)
//   core_word_addr        port C word address
//   core_data_in          port C write data
//   core_data_out         port C read data (pre-write word), registered
//   core_stall            port C access this cycle was dropped; pipeline holds
//   req_valid/req_ready   port B request handshake
//   req_byte_wr_en        port B write strobes (all 0 = read)
//   req_word_addr         port B word address
//   req_data_in           port B write data
//   resp_valid/resp_ready port B response handshake
//   resp_data_out         port B read data (pre-write word), held until consumed
// -----------------------------------------------------------------------------
module dual_port_data_memory #(
  parameter  int WIDTH     = 32,
  parameter  int SIZE      = 256,
  parameter  int COL_WIDTH = 8,
  parameter  int NUM_COL   = WIDTH / COL_WIDTH,
  parameter  int MAX_WAIT  = 4,
  localparam int LOGSIZE   = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               core_en,
  input  logic [NUM_COL-1:0] core_byte_wr_en,
  input  logic [LOGSIZE-1:0] core_word_addr,
  input  logic [WIDTH-1:0]   core_data_in,
  output logic [WIDTH-1:0]   core_data_out,
  output logic               core_stall,

  input  logic               req_valid,
  output logic               req_ready,
  input  logic [NUM_COL-1:0] req_byte_wr_en,
  input  logic [LOGSIZE-1:0] req_word_addr,
  input  logic [WIDTH-1:0]   req_data_in,

  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   resp_data_out
);

  // A zero-width counter is illegal, so MAX_WAIT=0 keeps a 1-bit counter that
  // simply never leaves 0.
  localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {B_IDLE, B_WAIT, B_RESP} b_state_t;

  b_state_t           b_state;
  logic [WCW-1:0]     wait_cnt;
  logic [NUM_COL-1:0] b_strb;
  logic [LOGSIZE-1:0] b_addr;
  logic [WIDTH-1:0]   b_data;

  logic [WIDTH-1:0]   mem [SIZE];

  logic               wait_full;
  logic               b_grant;
  logic               core_access;
  logic [LOGSIZE-1:0] acc_addr;
  logic [NUM_COL-1:0] acc_we;
  logic [WIDTH-1:0]   acc_data;
  logic [WIDTH-1:0]   rd_word;

  // ---------------------------------------------------------------------------
  // Arbitration: port B wins only when the core is idle or its wait budget is
  // spent; in the latter case the core access is dropped and reported as stall.
  // ---------------------------------------------------------------------------
  assign wait_full   = (wait_cnt == WAIT_LIMIT);
  assign b_grant     = (b_state == B_WAIT) && (!core_en || wait_full);
  assign core_stall  = (b_state == B_WAIT) && core_en && wait_full;
  assign core_access = core_en && !core_stall;

  // State is forced to B_IDLE while reset is low, so gating with reset only
  // matters for req_ready.
  assign req_ready  = reset && (b_state == B_IDLE);
  assign resp_valid = (b_state == B_RESP);

  // Single shared access port of the array.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    acc_addr = core_word_addr;
    acc_we   = '0;
    acc_data = core_data_in;
    if (b_grant) begin
      acc_addr = b_addr;
      acc_we   = b_strb;
      acc_data = b_data;
    end else if (core_access) begin
      acc_we   = core_byte_wr_en;
    end
  end

  // Read-first: this is the word as it stood before this cycle's write.
  assign rd_word = mem[acc_addr];

  // NOTE: the array has no reset on purpose -- it maps onto block RAM, and a
  // granted write must survive a later reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_COL; i++) begin
      if (acc_we[i]) begin
        mem[acc_addr][i*COL_WIDTH +: COL_WIDTH] <= acc_data[i*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Port B FSM and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      b_state       <= B_IDLE;
      wait_cnt      <= '0;
      b_strb        <= '0;
      b_addr        <= '0;
      b_data        <= '0;
      core_data_out <= '0;
      resp_data_out <= '0;
    end else begin
      if (core_access) begin
        core_data_out <= rd_word;
      end

      unique case (b_state)
        B_IDLE: begin
          if (req_valid) begin
            b_strb   <= req_byte_wr_en;
            b_addr   <= req_word_addr;
            b_data   <= req_data_in;
            wait_cnt <= '0;
            b_state  <= B_WAIT;
          end
        end
        B_WAIT: begin
          if (b_grant) begin
            resp_data_out <= rd_word;
            b_state       <= B_RESP;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        B_RESP: begin
          if (resp_ready) begin
            b_state <= B_IDLE;
          end
        end
        default: b_state <= B_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_port_data_memory.sv
// -----------------------------------------------------------------------------
// tb_dual_port_data_memory
//
// Directed bench for dual_port_data_memory (WIDTH=32, SIZE=256, MAX_WAIT=4).
// Inputs change 1 ns after a rising edge; outputs are sampled a further 1 ns
// later, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_dual_port_data_memory;

  localparam int WIDTH    = 32;
  localparam int SIZE     = 256;
  localparam int NUM_COL  = 4;
  localparam int MAX_WAIT = 4;
  localparam int LOGSIZE  = $clog2(SIZE);

  logic               clk = 1'b0;
  logic               reset;
  logic               core_en;
  logic [NUM_COL-1:0] core_byte_wr_en;
  logic [LOGSIZE-1:0] core_word_addr;
  logic [WIDTH-1:0]   core_data_in;
  logic [WIDTH-1:0]   core_data_out;
  logic               core_stall;
  logic               req_valid;
  logic               req_ready;
  logic [NUM_COL-1:0] req_byte_wr_en;
  logic [LOGSIZE-1:0] req_word_addr;
  logic [WIDTH-1:0]   req_data_in;
  logic               resp_valid;
  logic               resp_ready;
  logic [WIDTH-1:0]   resp_data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dual_port_data_memory #(
    .WIDTH    (WIDTH),
    .SIZE     (SIZE),
    .COL_WIDTH(8),
    .NUM_COL  (NUM_COL),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .core_en        (core_en),
    .core_byte_wr_en(core_byte_wr_en),
    .core_word_addr (core_word_addr),
    .core_data_in   (core_data_in),
    .core_data_out  (core_data_out),
    .core_stall     (core_stall),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_byte_wr_en (req_byte_wr_en),
    .req_word_addr  (req_word_addr),
    .req_data_in    (req_data_in),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data_out  (resp_data_out)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic core_op(input logic en, input logic [3:0] strb,
                         input int addr, input logic [31:0] data);
    core_en         = en;
    core_byte_wr_en = strb;
    core_word_addr  = LOGSIZE'(addr);
    core_data_in    = data;
  endtask

  task automatic b_req(input logic valid, input logic [3:0] strb,
                       input int addr, input logic [31:0] data);
    req_valid      = valid;
    req_byte_wr_en = strb;
    req_word_addr  = LOGSIZE'(addr);
    req_data_in    = data;
  endtask

  initial begin
    reset      = 1'b0;
    resp_ready = 1'b0;
    core_op(1'b0, 4'h0, 0, 32'h0);
    b_req(1'b0, 4'h0, 0, 32'h0);

    // ---- reset state ----
    step();
    check("rst_core_data_out", core_data_out, 32'h0);
    check("rst_resp_data_out", resp_data_out, 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_core_stall", 32'(core_stall), 32'd0);
    reset = 1'b1;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // ---- port C full write / read, then byte-lane write ----
    core_op(1'b1, 4'hF, 5, 32'hDEADBEEF); step();
    core_op(1'b1, 4'h0, 5, 32'h0);        step();
    check("c_read5_full", core_data_out, 32'hDEADBEEF);
    core_op(1'b1, 4'h1, 5, 32'h000000AA); step();
    core_op(1'b1, 4'h0, 5, 32'h0);        step();
    check("c_read5_lane0", core_data_out, 32'hDEADBEAA);
    core_op(1'b0, 4'h0, 7, 32'h0);        step();
    check("c_hold_idle", core_data_out, 32'hDEADBEAA);

    // ---- read-first on same-cycle write ----
    core_op(1'b1, 4'hF, 7, 32'h11111111); step();
    core_op(1'b1, 4'hF, 7, 32'h22222222); step();
    check("c_read_first", core_data_out, 32'h11111111);
    core_op(1'b1, 4'h0, 7, 32'h0);        step();
    check("c_read_after_wr", core_data_out, 32'h22222222);

    // ---- port B read with idle core, held response ----
    core_op(1'b0, 4'h0, 0, 32'h0);
    b_req(1'b1, 4'h0, 5, 32'h0);
    #1;
    check("b_rd_req_ready_idle", 32'(req_ready), 32'd1);
    step();                                   // accept edge N
    b_req(1'b0, 4'h0, 0, 32'h0);
    check("b_rd_wait_resp_valid", 32'(resp_valid), 32'd0);
    check("b_rd_wait_req_ready", 32'(req_ready), 32'd0);
    step();                                   // grant edge N+1
    check("b_rd_resp_valid", 32'(resp_valid), 32'd1);
    check("b_rd_resp_data", resp_data_out, 32'hDEADBEAA);
    for (int i = 0; i < 3; i++) begin
      step();
      check("b_rd_hold_valid", 32'(resp_valid), 32'd1);
      check("b_rd_hold_data", resp_data_out, 32'hDEADBEAA);
      check("b_rd_hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("b_rd_consumed_valid", 32'(resp_valid), 32'd0);
    check("b_rd_consumed_ready", 32'(req_ready), 32'd1);

    // ---- forced grant: port B write addr 9 with core busy ----
    core_op(1'b1, 4'hF, 9, 32'h99999999);  step();
    core_op(1'b1, 4'hF, 10, 32'h0A0A0A0A); step();
    core_op(1'b1, 4'h0, 5, 32'h0);
    b_req(1'b1, 4'hF, 9, 32'hCAFEF00D);
    step();                                   // accept edge N
    b_req(1'b0, 4'h0, 0, 32'h0);
    for (int i = 0; i < MAX_WAIT; i++) begin
      #1;
      check("b_wr_no_stall_yet", 32'(core_stall), 32'd0);
      step();
    end
    // Cycle after edge N+4: the forced-grant cycle. Core tries to write addr 10.
    core_op(1'b1, 4'hF, 10, 32'hBAD0BAD0);
    #1;
    check("b_wr_stall", 32'(core_stall), 32'd1);
    check("b_wr_stall_resp_valid", 32'(resp_valid), 32'd0);
    step();                                   // grant edge N+5
    check("b_wr_stall_dropped_out", core_data_out, 32'hDEADBEAA);
    check("b_wr_resp_valid", 32'(resp_valid), 32'd1);
    check("b_wr_resp_old_word", resp_data_out, 32'h99999999);
    core_op(1'b1, 4'h0, 9, 32'h0);
    #1;
    check("b_wr_stall_cleared", 32'(core_stall), 32'd0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("c_read9_old_in_resp", core_data_out, 32'hCAFEF00D);
    core_op(1'b1, 4'h0, 10, 32'h0); step();
    check("c_read10_unchanged", core_data_out, 32'h0A0A0A0A);

    // ---- interleaved lane writes to addr 12 across a forced grant ----
    core_op(1'b1, 4'hF, 12, 32'h00000000); step();
    core_op(1'b1, 4'h3, 12, 32'h11111111);
    b_req(1'b1, 4'hC, 12, 32'hAAAAAAAA);
    step();                                   // accept edge N; word 0000_1111
    b_req(1'b0, 4'h0, 0, 32'h0);
    core_op(1'b1, 4'hC, 12, 32'h22222222); step();   // 2222_1111
    core_op(1'b1, 4'h3, 12, 32'h33333333); step();   // 2222_3333
    core_op(1'b1, 4'hC, 12, 32'h44444444); step();   // 4444_3333
    core_op(1'b1, 4'h3, 12, 32'h55555555); step();   // 4444_5555
    check("mix_core_out_pre", core_data_out, 32'h44443333);
    core_op(1'b1, 4'hC, 12, 32'h66666666);           // dropped
    #1;
    check("mix_stall", 32'(core_stall), 32'd1);
    step();                                   // B writes upper lanes: AAAA_5555
    check("mix_resp_old", resp_data_out, 32'h44445555);
    check("mix_core_out_held", core_data_out, 32'h44443333);
    core_op(1'b1, 4'h3, 12, 32'h77777777); step();   // AAAA_7777
    check("mix_core_after_grant", core_data_out, 32'hAAAA5555);
    resp_ready = 1'b1;
    core_op(1'b1, 4'h0, 12, 32'h0); step();
    resp_ready = 1'b0;
    check("mix_final_word", core_data_out, 32'hAAAA7777);

    // ---- asynchronous reset while port B is waiting ----
    core_op(1'b1, 4'hF, 20, 32'h20202020); step();
    core_op(1'b1, 4'h0, 5, 32'h0);
    b_req(1'b1, 4'hF, 20, 32'hFFFFFFFF);
    step();                                   // accepted, now waiting
    b_req(1'b0, 4'h0, 0, 32'h0);
    step();
    #2;
    reset = 1'b0;                             // mid-cycle, no clock edge
    #1;
    check("arst_core_data_out", core_data_out, 32'h0);
    check("arst_resp_data_out", resp_data_out, 32'h0);
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd0);
    check("arst_core_stall", 32'(core_stall), 32'd0);
    core_op(1'b0, 4'h0, 0, 32'h0);
    step();
    reset = 1'b1;
    #1;
    check("arst_release_req_ready", 32'(req_ready), 32'd1);
    step();
    step();
    check("arst_no_resp", 32'(resp_valid), 32'd0);
    core_op(1'b1, 4'h0, 20, 32'h0); step();
    check("arst_array_unchanged", core_data_out, 32'h20202020);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_port_data_memory.md
# dual_port_data_memory

Parametrised successor to the core data memory: one word-organised, byte-writable RAM array shared between the pipeline MEM stage (port C) and a secondary bus master such as a debug/DMA/AXI-lite bridge (port B). Port C keeps the single-cycle synchronous-read contract the pipeline relies on. Port B uses a valid/ready request/response handshake, is served in idle core cycles, and has a bounded-wait starvation guard.

## Interface
- WIDTH, 32: bits per word
- SIZE, 256: words in array; power of two
- COL_WIDTH, 8: bits per byte lane
- NUM_COL, WIDTH/COL_WIDTH: byte lanes; WIDTH must equal NUM_COL*COL_WIDTH
- MAX_WAIT, 4: core-busy cycles port B may be denied before a forced grant; 0 allowed
- LOGSIZE (local), $clog2(SIZE): word address width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- core_en  in  1  port C access this cycle
- core_byte_wr_en  in  NUM_COL  port C byte-lane write strobes; all 0 = read
- core_word_addr  in  LOGSIZE  port C word address
- core_data_in  in  WIDTH  port C write data
- core_data_out  out  WIDTH  port C read data, registered
- core_stall  out  1  port C access this cycle was not performed; pipeline must hold
- req_valid  in  1  port B request valid
- req_ready  out  1  port B request accepted when valid&ready
- req_byte_wr_en  in  NUM_COL  port B write strobes; all 0 = read
- req_word_addr  in  LOGSIZE  port B word address
- req_data_in  in  WIDTH  port B write data
- resp_valid  out  1  port B response valid
- resp_ready  in  1  port B response consumed when valid&ready
- resp_data_out  out  WIDTH  port B read data

## Operation
- Single array, one access per cycle. Read-first: a read of the word written in the same cycle returns the old word; byte lanes with strobe 0 unchanged.
- Port C access performed in every cycle with core_en=1 and core_stall=0; core_data_out <= mem[core_word_addr] (pre-write). core_data_out holds when no port C access is performed.
- Port B FSM:
  - B_IDLE: req_ready=1. On req_valid: latch strobes/address/data, wait_cnt<=0, go B_WAIT.
  - B_WAIT: req_ready=0. Grant if core_en=0, or if wait_cnt==MAX_WAIT. On grant: perform latched access, resp_data_out <= pre-write word, go B_RESP. If not granted (core_en=1, wait_cnt<MAX_WAIT): wait_cnt++.
  - B_RESP: resp_valid=1, resp_data_out stable; on resp_ready go B_IDLE. Writes also respond (returns old word).
- core_stall = (state==B_WAIT) & core_en & (wait_cnt==MAX_WAIT); combinational. In that cycle port C access is dropped, array and core_data_out unchanged.
- wait_cnt width $clog2(MAX_WAIT+1), never exceeds MAX_WAIT.
- Memory contents are not reset.

## Timing
- Port C read latency 1 cycle: address at edge N, data valid after edge N+1.
- Port B minimum latency: accepted at edge N, granted at edge N+1, resp_valid high after edge N+1 (visible cycle N+1..). Maximum grant delay MAX_WAIT+1 cycles after accept.
- One port B transaction outstanding; no new req_ready until response consumed; req_ready=0 in B_WAIT and B_RESP.
- resp_valid held with constant resp_data_out until resp_ready; no timeout.
- Reset low (any time, async): state B_IDLE, wait_cnt 0, core_data_out 0, resp_data_out 0, resp_valid 0, core_stall 0, req_ready 0 while reset low. Pending or unresponded port B transaction is dropped; a write already granted stays in the array. First acceptance possible at the first edge after reset deasserts.

## Test plan
- Port C write addr 5 data 0xDEADBEEF strobes 1111, then read addr 5 -> core_data_out 0xDEADBEEF one cycle later; write 0x000000AA strobe 0001 -> read 0xDEADBEAA.
- Port C write addr 7 = 0x11111111, then same-cycle write 0x22222222 and read addr 7 -> core_data_out 0x11111111; next read -> 0x22222222.
- Port B read addr 5 with core_en=0 -> req accepted edge N, resp_valid at N+1 with 0xDEADBEAA; resp_ready held low 3 cycles -> resp_valid/data stable, req_ready 0.
- MAX_WAIT=4, core_en=1 continuously, port B write addr 9 = 0xCAFEF00D -> core_stall high exactly one cycle, 5 cycles after accept; port C op of that cycle not performed; subsequent port C read addr 9 -> 0xCAFEF00D.
- Port B and port C writes same word alternating strobes 0011/1100 across a forced grant -> final word matches sequential order of performed accesses.
- reset low in B_WAIT -> all outputs 0 immediately (async); after release req_ready 1, latched request not performed, array unchanged.
